srl_fifo_ctrl: RTL and testbench

SRL_FIFO_CTRL -- requirements
Module: srl_fifo_ctrl

---
 rtl/srl_fifo_ctrl_pkg.sv | 14 +
 rtl/srl_fifo_storage.sv | 28 ++
 rtl/srl_fifo_ctrl.sv | 83 ++++++++
 tb/tb_srl_fifo_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/srl_fifo_ctrl_pkg.sv
// Shared sizing helpers for the SRL FIFO controller and its shift-register storage.
// Pure constant functions; no latency, no flow control.
package srl_fifo_ctrl_pkg;

    function automatic int occ_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // The read address must reach every entry, and a FIFO needs at least two slots.
    function automatic bit depth_ok(input int depth, input int addr_width);
        return (depth >= 2) && ((2 ** addr_width) >= depth);
    endfunction

endpackage

// File: rtl/srl_fifo_storage.sv
// Shift-register array: new data enters slot 0 on we_i, oldest sits at the highest live slot.
// Write takes effect on the next edge, read is combinational; no backpressure, no reset.
module srl_fifo_storage #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 6
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout_o = mem_q[addr_i];

endmodule

// File: rtl/srl_fifo_ctrl.sv
// SRL FIFO controller: occupancy count, registered empty/full flags, storage address/enable.
// One-cycle write-to-read latency; pushes blocked when full, pops blocked when empty.
module srl_fifo_ctrl
    import srl_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_write,
    input  logic                    if_write_ce,
    input  logic [DATA_WIDTH-1:0]   if_din,
    output logic                    if_full_n,
    input  logic                    if_read,
    input  logic                    if_read_ce,
    output logic [DATA_WIDTH-1:0]   if_dout,
    output logic                    if_empty_n,
    output logic [ADDR_WIDTH:0]     if_num_data_valid
);

    localparam int CW     = occ_width(ADDR_WIDTH);
    localparam bit CFG_OK = depth_ok(DEPTH, ADDR_WIDTH);

    generate
        if (!CFG_OK) begin : g_cfg_err
            $error("srl_fifo_ctrl: DEPTH must be >= 2 and fit in 2**ADDR_WIDTH");
        end
    endgenerate

    logic [CW-1:0]         count_q, count_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Gating with reset keeps the storage frozen while the FIFO is being cleared.
    assign push = if_write & if_write_ce & full_n_q & ~reset;
    assign pop  = if_read & if_read_ce & empty_n_q & ~reset;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        empty_n_d = (count_d != '0);
        full_n_d  = (count_d < CW'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
        end else begin
            count_q   <= count_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
        end
    end

    assign rd_addr = (count_q != '0) ? ADDR_WIDTH'(count_q - CW'(1)) : '0;

    srl_fifo_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk    (clk),
        .we_i   (push),
        .din_i  (if_din),
        .addr_i (rd_addr),
        .dout_o (if_dout)
    );

    assign if_full_n         = full_n_q;
    assign if_empty_n        = empty_n_q;
    assign if_num_data_valid = count_q;

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Self-checking bench for srl_fifo_ctrl (DATA_WIDTH=8, DEPTH=6) against a queue model.
module tb_srl_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_write, if_write_ce, if_read, if_read_ce;
    logic [DW-1:0] if_din;
    logic          if_full_n, if_empty_n;
    logic [DW-1:0] if_dout;
    logic [AW:0]   if_num_data_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] model[$];

    always #5 clk = ~clk;

    srl_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .if_write          (if_write),
        .if_write_ce       (if_write_ce),
        .if_din            (if_din),
        .if_full_n         (if_full_n),
        .if_read           (if_read),
        .if_read_ce        (if_read_ce),
        .if_dout           (if_dout),
        .if_empty_n        (if_empty_n),
        .if_num_data_valid (if_num_data_valid)
    );

    // Drive one cycle of requests, advance past the edge, and update the model.
    task automatic cyc(input bit w, input bit wce, input logic [DW-1:0] d,
                       input bit r, input bit rce);
        bit pu, po;
        if_write    = w;
        if_write_ce = wce;
        if_din      = d;
        if_read     = r;
        if_read_ce  = rce;
        pu = w && wce && (model.size() < DEPTH);
        po = r && rce && (model.size() > 0);
        @(posedge clk);
        #1;
        if (po) void'(model.pop_front());
        if (pu) model.push_back(d);
        if_write = 1'b0; if_write_ce = 1'b0; if_read = 1'b0; if_read_ce = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_write = 0; if_write_ce = 0; if_read = 0; if_read_ce = 0; if_din = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (if_num_data_valid !== 4'd0 || if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: cnt=%0d empty_n=%b full_n=%b want cnt=0 empty_n=0 full_n=1",
                     if_num_data_valid, if_empty_n, if_full_n);
        end
        reset = 1'b0;
        model.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_first_push();
        cyc(1, 1, 8'h11, 0, 0);
        n_checks++;
        if (if_empty_n !== 1'b1 || if_dout !== 8'h11 || if_num_data_valid !== 4'd1) begin
            n_fail++;
            $display("FAIL first_push: empty_n=%b dout=%h cnt=%0d want 1 11 1",
                     if_empty_n, if_dout, if_num_data_valid);
        end
        cyc(0, 0, 0, 1, 1);
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= DEPTH; i++) cyc(1, 1, DW'(i), 0, 0);
        n_checks++;
        if (if_full_n !== 1'b0 || if_num_data_valid !== 4'd6) begin
            n_fail++;
            $display("FAIL fill_full: full_n=%b cnt=%0d want 0 6", if_full_n, if_num_data_valid);
        end
        cyc(1, 1, 8'h07, 0, 0);
        n_checks++;
        if (if_num_data_valid !== 4'd6 || if_dout !== 8'h01) begin
            n_fail++;
            $display("FAIL push_when_full: cnt=%0d dout=%h want 6 01", if_num_data_valid, if_dout);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            n_checks++;
            if (if_dout !== DW'(i) || if_empty_n !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_order: dout=%h empty_n=%b want %h 1", if_dout, if_empty_n, DW'(i));
            end
            cyc(0, 0, 0, 1, 1);
        end
        n_checks++;
        if (if_empty_n !== 1'b0 || if_num_data_valid !== 4'd0) begin
            n_fail++;
            $display("FAIL drained_empty: empty_n=%b cnt=%0d want 0 0", if_empty_n, if_num_data_valid);
        end
    endtask

    task automatic test_simul_push_pop();
        cyc(1, 1, 8'h0A, 0, 0);
        cyc(1, 1, 8'h0B, 0, 0);
        cyc(1, 1, 8'h0C, 0, 0);
        cyc(1, 1, 8'h0D, 1, 1);
        n_checks++;
        if (if_num_data_valid !== 4'd3 || if_dout !== 8'h0B) begin
            n_fail++;
            $display("FAIL simul_mid: cnt=%0d dout=%h want 3 0b", if_num_data_valid, if_dout);
        end
        cyc(0, 0, 0, 1, 1);
        n_checks++;
        if (if_dout !== 8'h0C) begin
            n_fail++;
            $display("FAIL simul_next1: dout=%h want 0c", if_dout);
        end
        cyc(0, 0, 0, 1, 1);
        n_checks++;
        if (if_dout !== 8'h0D || if_num_data_valid !== 4'd1) begin
            n_fail++;
            $display("FAIL simul_next2: dout=%h cnt=%0d want 0d 1", if_dout, if_num_data_valid);
        end
        cyc(0, 0, 0, 1, 1);
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, DW'(8'h20 + i), 0, 0);
        cyc(1, 1, 8'hEE, 1, 1);
        n_checks++;
        if (if_num_data_valid !== 4'd5 || if_full_n !== 1'b1 || if_dout !== 8'h21) begin
            n_fail++;
            $display("FAIL full_simul: cnt=%0d full_n=%b dout=%h want 5 1 21",
                     if_num_data_valid, if_full_n, if_dout);
        end
        while (model.size() > 0) cyc(0, 0, 0, 1, 1);
    endtask

    task automatic test_ce_and_empty_pop();
        cyc(1, 1, 8'h33, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'h44, 0, 0);
        n_checks++;
        if (if_num_data_valid !== 4'd1 || if_dout !== 8'h33) begin
            n_fail++;
            $display("FAIL write_ce_low: cnt=%0d dout=%h want 1 33", if_num_data_valid, if_dout);
        end
        cyc(0, 0, 0, 1, 0);
        n_checks++;
        if (if_num_data_valid !== 4'd1) begin
            n_fail++;
            $display("FAIL read_ce_low: cnt=%0d want 1", if_num_data_valid);
        end
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        n_checks++;
        if (if_num_data_valid !== 4'd0 || if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_pop: cnt=%0d empty_n=%b full_n=%b want 0 0 1",
                     if_num_data_valid, if_empty_n, if_full_n);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) cyc(1, 1, DW'(8'h60 + i), 0, 0);
        n_checks++;
        if (if_num_data_valid !== 4'd4) begin
            n_fail++;
            $display("FAIL pre_reset_cnt: cnt=%0d want 4", if_num_data_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        model.delete();
        n_checks++;
        if (if_num_data_valid !== 4'd0 || if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: cnt=%0d empty_n=%b full_n=%b want 0 0 1",
                     if_num_data_valid, if_empty_n, if_full_n);
        end
        // Requests during reset must be ignored.
        if_write = 1; if_write_ce = 1; if_din = 8'h99; if_read = 1; if_read_ce = 1;
        @(posedge clk); #1;
        if_write = 0; if_write_ce = 0; if_read = 0; if_read_ce = 0;
        reset = 1'b0;
        n_checks++;
        if (if_num_data_valid !== 4'd0 || if_empty_n !== 1'b0) begin
            n_fail++;
            $display("FAIL push_in_reset: cnt=%0d empty_n=%b want 0 0", if_num_data_valid, if_empty_n);
        end
        cyc(1, 1, 8'h55, 0, 0);
        n_checks++;
        if (if_dout !== 8'h55 || if_num_data_valid !== 4'd1 || if_empty_n !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_push: dout=%h cnt=%0d empty_n=%b want 55 1 1",
                     if_dout, if_num_data_valid, if_empty_n);
        end
        cyc(0, 0, 0, 1, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0), DW'($urandom),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0));
            n_checks++;
            if (if_num_data_valid !== (AW+1)'(model.size())
                || if_empty_n !== (model.size() > 0)
                || if_full_n !== (model.size() < DEPTH)
                || (model.size() > 0 && if_dout !== model[0])) begin
                n_fail++;
                $display("FAIL random[%0d]: cnt=%0d e=%b f=%b dout=%h want cnt=%0d front=%h",
                         n, if_num_data_valid, if_empty_n, if_full_n, if_dout,
                         model.size(), (model.size() > 0) ? model[0] : 8'h00);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_fill_drain();
        test_simul_push_pop();
        test_full_simul();
        test_ce_and_empty_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
